// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, line constants and parity helper for the RX and TX paths
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} uart_rx_state_t;
  localparam logic UART_IDLE_LVL = 1'b1;
  // Expected parity bit; data is zero-extended to 9 bits, which leaves parity unchanged
  function automatic logic parity_calc(input logic [8:0] data, input logic odd);
    return ^data ^ odd;
  endfunction
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer with a configurable reset level
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
)(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= {2{RST_VAL}};
    else     {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: UART receive path delivering framed words on a valid/ready register
module uart_rx_deframer import uart_pkg::*; #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W + 1);
  uart_rx_state_t state, state_n;
  logic rxs, tick, last_bit, deliver, load, par_q;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_W-1:0] shift;
  uart_sync2 #(.RST_VAL(UART_IDLE_LVL)) u_sync (.clk(clk), .rst(rst), .d(rx), .q(rxs));
  // START waits half a bit so every later sample lands mid-bit
  assign tick     = cnt == ((state == START) ? CW'(CLKS_PER_BIT / 2 - 1) : CW'(CLKS_PER_BIT - 1));
  assign last_bit = bit_cnt == BW'(DATA_W - 1);
  assign deliver  = state == STOP && tick;
  assign load     = deliver && (!rx_valid || rx_ready);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = rxs ? IDLE : START;
      START:   state_n = !tick ? START : rxs ? IDLE : DATA;
      DATA:    state_n = !(tick && last_bit) ? DATA : (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  state_n = tick ? STOP : PARITY;
      STOP:    state_n = !tick ? STOP : rxs ? IDLE : BREAK;
      BREAK:   state_n = (rxs == UART_IDLE_LVL) ? IDLE : BREAK;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par_q   <= 1'b0;
    end else begin
      cnt <= (state == IDLE || state == BREAK || tick) ? '0 : cnt + CW'(1);
      if (state == IDLE) bit_cnt <= '0;
      else if (state == DATA && tick) bit_cnt <= bit_cnt + BW'(1);
      if (state == DATA && tick) shift <= {rxs, shift[DATA_W-1:1]};
      if (state == IDLE) par_q <= 1'b0;
      else if (state == PARITY && tick) par_q <= rxs != parity_calc(9'(shift), PARITY_ODD != 0);
    end
  // A completed frame is dropped, not queued, when the held word is still unaccepted
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= deliver && rx_valid && !rx_ready;
      if (load) begin
        rx_data    <= shift;
        rx_valid   <= 1'b1;
        parity_err <= (PARITY_EN != 0) && par_q;
        frame_err  <= !rxs;
      end else if (rx_valid && rx_ready) begin
        rx_data    <= '0;
        rx_valid   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
    end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: table-driven and scoreboarded bench for uart_rx_deframer
module tb_uart_rx_deframer;
  import uart_pkg::*;
  localparam int CPB = 16;
  typedef struct packed {logic [7:0] d; logic pe; logic fe;} exp_t;
  typedef struct {logic [7:0] d; logic par_flip; logic stop; logic exp_pe; logic exp_fe;} vec_t;
  logic clk = 1'b0, rst = 1'b1, rx0 = 1'b1, rx1 = 1'b1, rdy0 = 1'b1, rdy1 = 1'b1;
  logic [7:0] d0, d1, ovr_data, cap_d;
  logic v0, v1, pe0, pe1, fe0, fe1, ov0, ov1, cap_v, cap_pe, cap_fe;
  exp_t sb[$];
  exp_t e;
  vec_t tbl[6];
  int errors = 0, checks = 0, ovr_cnt = 0, lat;
  always #5 clk = ~clk;
  uart_rx_deframer #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst(rst), .rx(rx0), .rx_data(d0), .rx_valid(v0), .rx_ready(rdy0),
    .parity_err(pe0), .frame_err(fe0), .overrun(ov0));
  uart_rx_deframer #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst(rst), .rx(rx1), .rx_data(d1), .rx_valid(v1), .rx_ready(rdy1),
    .parity_err(pe1), .frame_err(fe1), .overrun(ov1));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push(input logic [7:0] d, input logic pe, input logic fe);
    exp_t t;
    t.d = d; t.pe = pe; t.fe = fe;
    sb.push_back(t);
  endtask
  task automatic bit_out(input int ln, input logic v);
    if (ln == 0) rx0 = v; else rx1 = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input int ln, input logic [7:0] d, input logic pen, input logic pbit, input logic stop);
    bit_out(ln, 1'b0);
    for (int i = 0; i < 8; i++) bit_out(ln, d[i]);
    if (pen) bit_out(ln, pbit);
    bit_out(ln, stop);
  endtask
  task automatic send_ok(input logic [7:0] d);
    push(d, 1'b0, 1'b0);
    send_frame(0, d, 1'b1, ^d, 1'b1);
    bit_out(0, 1'b1);
  endtask
  task automatic drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", sb.size(), 0);
  endtask
  initial begin
    fork
      forever begin
        @(negedge clk);
        if (ov0) begin
          ovr_cnt++;
          ovr_data = d0;
        end
        if (v0 && rdy0) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected none", d0);
          end else begin
            e = sb.pop_front();
            chk("rx_data", d0, e.d);
            chk("parity_err", pe0, e.pe);
            chk("frame_err", fe0, e.fe);
          end
        end
      end
    join_none
    tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{8'h7E, 1'b0, 1'b0, 1'b0, 1'b1};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", v0, 0);
    chk("rst_data", d0, 0);
    chk("rst_perr", pe0, 0);
    chk("rst_ferr", fe0, 0);
    chk("rst_ovr", ov0, 0);
    chk("rst_valid1", v1, 0);
    chk("rst_state", 32'(dut0.state), 32'(IDLE));
    rst = 1'b0;
    bit_out(0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      push(tbl[i].d, tbl[i].exp_pe, tbl[i].exp_fe);
      send_frame(0, tbl[i].d, 1'b1, (^tbl[i].d) ^ tbl[i].par_flip, tbl[i].stop);
      bit_out(0, 1'b1);
      bit_out(0, 1'b1);
    end
    drain();
    // short low pulse must be rejected as a glitch
    rx0 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx0 = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("glitch_state", 32'(dut0.state), 32'(IDLE));
    chk("glitch_valid", v0, 0);
    send_ok(8'h3C);
    drain();
    // framing error followed by a held-low line
    push(8'hFF, 1'b0, 1'b1);
    send_frame(0, 8'hFF, 1'b1, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    chk("break_state", 32'(dut0.state), 32'(BREAK));
    bit_out(0, 1'b1);
    bit_out(0, 1'b1);
    send_ok(8'h12);
    drain();
    // overrun with a stalled consumer
    rdy0 = 1'b0;
    push(8'h11, 1'b0, 1'b0);
    send_frame(0, 8'h11, 1'b1, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b1, 1'b0, 1'b1);
    bit_out(0, 1'b1);
    chk("ovr_count", ovr_cnt, 1);
    chk("ovr_data", ovr_data, 8'h11);
    chk("hold_valid", v0, 1);
    chk("hold_data", d0, 8'h11);
    rdy0 = 1'b1;
    @(posedge clk);
    #1;
    chk("accept_valid", v0, 0);
    chk("accept_data", d0, 0);
    drain();
    // reset in the middle of a frame while a word is held
    rdy0 = 1'b0;
    send_frame(0, 8'h33, 1'b1, 1'b0, 1'b1);
    bit_out(0, 1'b1);
    chk("pre_rst_valid", v0, 1);
    chk("pre_rst_data", d0, 8'h33);
    fork
      send_frame(0, 8'h5A, 1'b1, 1'b0, 1'b1);
      begin
        repeat (CPB * 5 + CPB / 2) @(posedge clk);
        #1;
        chk("mid_state_data", 32'(dut0.state), 32'(DATA));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", v0, 0);
        chk("mid_rst_data", d0, 0);
        chk("mid_rst_perr", pe0, 0);
        chk("mid_rst_ferr", fe0, 0);
        chk("mid_rst_ovr", ov0, 0);
      end
    join
    rdy0 = 1'b1;
    rst = 1'b0;
    bit_out(0, 1'b1);
    send_ok(8'h5A);
    drain();
    // no-parity instance: frame ends one bit earlier
    cap_v = 1'b0;
    cap_d = '0;
    cap_pe = 1'b1;
    cap_fe = 1'b1;
    lat = 0;
    fork
      send_frame(1, 8'h5A, 1'b0, 1'b0, 1'b1);
      begin
        while (!v1 && lat < 300) begin
          @(posedge clk);
          #1;
          lat++;
        end
        cap_v = v1;
        cap_d = d1;
        cap_pe = pe1;
        cap_fe = fe1;
      end
    join
    bit_out(1, 1'b1);
    chk("nopar_valid", cap_v, 1);
    chk("nopar_data", cap_d, 8'h5A);
    chk("nopar_perr", cap_pe, 0);
    chk("nopar_ferr", cap_fe, 0);
    chk("nopar_latency", (lat >= 9 * CPB && lat < 10 * CPB) ? 1 : 0, 1);
    chk("nopar_after", v1, 0);
    chk("ovr_total", ovr_cnt, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
